// File: rtl/special_alu_core_if.sv
// Operand-in / result-out bus of the special ALU core.
// The producer pushes operands on the a side; the consumer pops results on the b side.
interface special_alu_core_if #(
  parameter int OPW = 8
);
  logic           a_valid;
  logic           a_ready;
  logic [OPW-1:0] a_operand;
  logic           b_valid;
  logic           b_ready;
  logic [2:0]     b_operation;
  logic [10:0]    b_result;

  modport master (
    output a_valid, a_operand, b_ready, b_operation,
    input  a_ready, b_valid, b_result
  );

  modport slave (
    input  a_valid, a_operand, b_ready, b_operation,
    output a_ready, b_valid, b_result
  );
endinterface

// File: rtl/special_alu_core.sv
// Eight-entry operand FIFO with a combinational reduction ALU on its contents.
// Oldest operand sits in entry 0; a full buffer drops its oldest entry on push.
module special_alu_core #(
  parameter int DEPTH = 8,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  special_alu_core_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD2 = 3'd0,
    OP_SUB2 = 3'd1,
    OP_OR2  = 3'd2,
    OP_AND2 = 3'd3,
    OP_OR   = 3'd4,
    OP_AND  = 3'd5,
    OP_SUM  = 3'd6,
    OP_AVG  = 3'd7
  } op_e;

  localparam logic [3:0] FULL = 4'(DEPTH);

  logic [OPW-1:0] r_buf [DEPTH];
  logic [3:0]     r_count;

  logic           w_a_hs;
  logic           w_b_hs;
  logic           w_shift;
  logic [3:0]     w_base;
  logic [OPW-1:0] w_buf_next [DEPTH];
  logic [10:0]    w_sum;
  logic [OPW-1:0] w_or;
  logic [OPW-1:0] w_and;
  logic [OPW-1:0] w_item1_z;
  logic [OPW-1:0] w_item1_f;
  logic [3:0]     w_div;
  logic [10:0]    w_res;

  // Operands are always accepted outside reset, so a_ready simply follows rstn.
  assign bus.a_ready  = rstn;
  assign bus.b_valid  = rstn & (r_count != 4'd0);
  assign bus.b_result = w_res;

  assign w_a_hs  = bus.a_valid & bus.a_ready;
  assign w_b_hs  = bus.b_valid & bus.b_ready;
  // A pop, or a push into a full buffer, retires the oldest entry.
  assign w_shift = w_b_hs | (w_a_hs & (r_count == FULL));
  assign w_base  = r_count - {3'd0, w_shift};

  // Next buffer image: optional shift toward entry 0, then append at w_base.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_buf_next[i] = r_buf[i];
    end
    if (w_shift) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_buf_next[i] = r_buf[i + 1];
      end
      w_buf_next[DEPTH - 1] = '0;
    end else begin
      w_buf_next[DEPTH - 1] = r_buf[DEPTH - 1];
    end
    if (w_a_hs) begin
      w_buf_next[w_base[2:0]] = bus.a_operand;
    end else begin
      w_buf_next[0] = w_buf_next[0];
    end
  end

  // Buffer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_count <= 4'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= w_buf_next[i];
      end
      r_count <= w_base + {3'd0, w_a_hs};
    end
  end

  // Reductions over valid entries; absent entries are neutral for each operator.
  always_comb begin
    w_sum = 11'd0;
    w_or  = '0;
    w_and = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (4'(i) < r_count) begin
        w_sum = w_sum + {3'd0, r_buf[i]};
        w_or  = w_or | r_buf[i];
        w_and = w_and & r_buf[i];
      end else begin
        w_sum = w_sum;
      end
    end
    w_item1_z = (r_count > 4'd1) ? r_buf[1] : 8'h00;
    w_item1_f = (r_count > 4'd1) ? r_buf[1] : 8'hFF;
    w_div     = (r_count == 4'd0) ? 4'd1 : r_count;
  end

  // Result mux; an empty buffer or active reset forces zero.
  always_comb begin
    w_res = 11'd0;
    if (!rstn || (r_count == 4'd0)) begin
      w_res = 11'd0;
    end else begin
      case (op_e'(bus.b_operation))
        OP_ADD2: w_res = {3'd0, r_buf[0]} + {3'd0, w_item1_z};
        OP_SUB2: w_res = {3'd0, r_buf[0]} - {3'd0, w_item1_z};
        OP_OR2:  w_res = {3'd0, r_buf[0] | w_item1_z};
        OP_AND2: w_res = {3'd0, r_buf[0] & w_item1_f};
        OP_OR:   w_res = {3'd0, w_or};
        OP_AND:  w_res = {3'd0, w_and};
        OP_SUM:  w_res = w_sum;
        OP_AVG:  w_res = w_sum / {7'd0, w_div};
        default: w_res = 11'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_special_alu_core.sv
// Random and directed bench for special_alu_core against a queue-based reference model.
module tb_special_alu_core;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;
  logic [7:0] q[$];

  special_alu_core_if bus_if ();

  special_alu_core #(.DEPTH(8), .OPW(8)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result computed from the queue contents with plain integer arithmetic.
  function automatic logic [10:0] ref_res(input logic [2:0] op);
    int n, s, o, a, i0, i1, r;
    n = q.size();
    if (n == 0) return 11'd0;
    s = 0; o = 0; a = 255;
    foreach (q[k]) begin
      s += int'(q[k]);
      o |= int'(q[k]);
      a &= int'(q[k]);
    end
    i0 = int'(q[0]);
    i1 = (n > 1) ? int'(q[1]) : ((op == 3'd3) ? 255 : 0);
    case (op)
      3'd0: r = i0 + i1;
      3'd1: r = (i0 - i1) & 2047;
      3'd2: r = i0 | i1;
      3'd3: r = i0 & i1;
      3'd4: r = o;
      3'd5: r = a;
      3'd6: r = s;
      default: r = s / n;
    endcase
    return 11'(r);
  endfunction

  task automatic cyc(input logic rn, input logic av, input logic [7:0] ao,
                     input logic br, input logic [2:0] op);
    logic a_hs, b_hs;
    @(negedge clk);
    rstn = rn;
    bus_if.a_valid = av;
    bus_if.a_operand = ao;
    bus_if.b_ready = br;
    bus_if.b_operation = op;
    #1;
    check_eq("a_ready", {15'd0, bus_if.a_ready}, {15'd0, rn});
    check_eq("b_valid", {15'd0, bus_if.b_valid}, {15'd0, (rn && q.size() != 0)});
    check_eq("b_result", {5'd0, bus_if.b_result}, rn ? {5'd0, ref_res(op)} : 16'd0);
    a_hs = rn & av;
    b_hs = rn & br & (q.size() != 0);
    @(posedge clk);
    if (!rn) begin
      q.delete();
    end else begin
      if (b_hs) void'(q.pop_front());
      if (a_hs) q.push_back(ao);
      if (q.size() > 8) void'(q.pop_front());
    end
  endtask

  // Idle probe of the combinational result for a fixed expected constant.
  task automatic peek(input string tag, input logic [2:0] op, input logic [10:0] exp);
    @(negedge clk);
    rstn = 1'b1;
    bus_if.a_valid = 1'b0;
    bus_if.b_ready = 1'b0;
    bus_if.b_operation = op;
    #1;
    check_eq(tag, {5'd0, bus_if.b_result}, {5'd0, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    bus_if.a_valid = 1'b0;
    bus_if.a_operand = 8'h00;
    bus_if.b_ready = 1'b0;
    bus_if.b_operation = 3'd0;
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 3'd6);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);

    // Subtract with wrap, then one pop leaves one entry.
    cyc(1'b1, 1'b1, 8'h05, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 8'h07, 1'b0, 3'd0);
    peek("sub2_wrap", 3'd1, 11'h7FE);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 3'd1);
    peek("after_pop_sum", 3'd6, 11'h007);

    // Single entry: absent partner is FF for AND2, 00 for ADD2.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 8'h3C, 1'b0, 3'd0);
    peek("and2_single", 3'd3, 11'h03C);
    peek("add2_single", 3'd0, 11'h03C);

    // Overfill with 1..10 keeps the newest eight.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int i = 1; i <= 10; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 3'd0);
    peek("sum_full", 3'd6, 11'h034);
    peek("avg_full", 3'd7, 11'h006);

    // Full of FF, then simultaneous push and pop at count 8.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0);
    peek("sum_ff", 3'd6, 11'h7F8);
    cyc(1'b1, 1'b1, 8'h00, 1'b1, 3'd6);
    peek("sum_swap", 3'd6, 11'h6F9);
    peek("and_swap", 3'd5, 11'h000);

    // Empty buffer ignores b_ready for every opcode.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int op = 0; op < 8; op++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 3'(op));
    peek("empty_res", 3'd5, 11'h000);

    // Mid-stream reset discards three held operands.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 8'h99, 1'b0, 3'd6);
    peek("post_rst_sum", 3'd6, 11'h000);
    check_eq("post_rst_valid", {15'd0, bus_if.b_valid}, 16'd0);
    check_eq("post_rst_ready", {15'd0, bus_if.a_ready}, 16'd1);

    // Random traffic with occasional resets and biased operand values.
    for (int t = 0; t < 3000; t++) begin
      logic [7:0] v;
      case ($urandom_range(0, 5))
        0: v = 8'hFF;
        1: v = 8'h00;
        default: v = 8'($urandom);
      endcase
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6), v,
          ($urandom_range(0, 9) < 4), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/special_alu_core.md
SPECIAL_ALU_CORE -- requirements
Module: special_alu_core

Interface
REQ-001 SHALL have parameter DEPTH, default 8, operand buffer depth; 8 is the only supported value.
REQ-002 SHALL have parameter OPW, default 8, operand width; 8 is the only supported value.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port a_valid  input  1  operand offered.
REQ-006 SHALL have port a_ready  output  1  operand accepted when high.
REQ-007 SHALL have port a_operand  input  8  operand value.
REQ-008 SHALL have port b_valid  output  1  result available.
REQ-009 SHALL have port b_ready  input  1  consumer takes the result.
REQ-010 SHALL have port b_operation  input  3  operation selected by the consumer, qualified by b_ready.
REQ-011 SHALL have port b_result  output  11  result of b_operation on the current buffer contents.

Function
REQ-012 SHALL define a_hs = a_valid & a_ready and b_hs = b_valid & b_ready.
REQ-013 SHALL hold up to 8 operands in arrival order, with a count 0..8; item0 = oldest, item1 = next oldest.
REQ-014 SHALL drive a_ready = 1 in every cycle after reset; the block never back-pressures operands.
REQ-015 SHALL drive b_valid = (count != 0).
REQ-016 SHALL compute b_result combinationally, zero cycle latency, from b_operation and the registered buffer state in the same cycle.
REQ-017 SHALL, on a_hs without b_hs: append a_operand; count+1, saturating at 8; when full, the oldest entry is discarded.
REQ-018 SHALL, on b_hs without a_hs: remove the oldest entry; count-1. Exactly one entry is removed per b_hs, for every operation.
REQ-019 SHALL, on simultaneous a_hs and b_hs: remove the oldest entry, append a_operand, and leave count unchanged, including at count 8.
REQ-020 SHALL treat a missing item (index >= count) as 8'hFF for AND2/AND and 8'h00 for all other operations.
REQ-021 SHALL implement opcode 0 ADD2: item0 + item1, 11-bit.
REQ-022 SHALL implement opcode 1 SUB2: item0 - item1, modulo 2^11.
REQ-023 SHALL implement opcode 2 OR2: item0 | item1, zero-extended.
REQ-024 SHALL implement opcode 3 AND2: item0 & item1, zero-extended.
REQ-025 SHALL implement opcode 4 OR: bitwise OR of all count items, zero-extended.
REQ-026 SHALL implement opcode 5 AND: bitwise AND of all count items, zero-extended.
REQ-027 SHALL implement opcode 6 SUM: sum of all count items; max 2040, no overflow in 11 bits.
REQ-028 SHALL implement opcode 7 AVG: floor(SUM / count).
REQ-029 SHALL drive b_result = 11'h000 whenever count = 0, for all opcodes; no division by zero.
REQ-030 SHALL ignore b_ready, and change no state, while b_valid = 0.

Reset
REQ-031 SHALL, while rstn = 0 at a rising clk edge, clear count to 0 and clear all buffer entries to 8'h00.
REQ-032 SHALL hold outputs a_ready = 0, b_valid = 0 and b_result = 11'h000 while rstn is low.
REQ-033 SHALL discard pending contents when reset is asserted mid-stream; a_hs in a reset cycle is ignored.

Verification
REQ-034 SHALL pass: push 8'h05 then 8'h07, b_operation=1, b_ready=1 -> b_result 11'h7FE, count 1.
REQ-035 SHALL pass: push single 8'h3C, b_operation=3 -> b_result 11'h03C (missing item0 partner = FF); with b_operation=0 -> 11'h03C.
REQ-036 SHALL pass: push 10 operands 1..10 with no pops -> count 8; b_operation=6 -> 11'h034 (3+..+10=52); b_operation=7 -> 11'h006.
REQ-037 SHALL pass: count 8 holding 8 x 8'hFF, b_operation=6 -> 11'h7F8; same cycle a_hs with 8'h00 and b_hs -> count stays 8, next SUM 11'h6F9.
REQ-038 SHALL pass: empty buffer, b_ready=1 for any opcode -> b_valid 0, b_result 11'h000, count stays 0.
REQ-039 SHALL pass: 3 operands held, rstn low for one cycle mid-stream -> next cycle count 0, b_valid 0, a_ready 1 after release.
